// File: rtl/pulse_seq_ctrl.sv
// Programmable one-hot phase sequencer: steps through enabled phases with a per-phase
// dwell time, a direction and a round count, under a start/stop/done handshake.
module pulse_seq_ctrl #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8,
    parameter int unsigned RW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [DW-1:0] dwell,
    input  logic [RW-1:0] rounds,
    input  logic [N-1:0]  mask,
    input  logic          dir,
    output logic [N-1:0]  out,
    output logic          busy,
    output logic          done
);

    localparam int unsigned IW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  out_q, out_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [RW-1:0] round_cnt_q, round_cnt_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [RW-1:0] rounds_q, rounds_d;
    logic [N-1:0]  mask_q, mask_d;
    logic          dir_q, dir_d;
    logic [IW-1:0] nxt_idx;
    logic          wrap;

    // First enabled phase in sequence order: highest bit for dir=0, lowest for dir=1.
    function automatic logic [IW-1:0] first_phase(input logic [N-1:0] m, input logic d);
        logic [IW-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (d) begin
                if (m[N-1-i]) res = IW'(N - 1 - i);
            end else begin
                if (m[i]) res = IW'(i);
            end
        end
        return res;
    endfunction

    function automatic logic [IW-1:0] next_phase(input logic [N-1:0] m, input logic d,
                                                 input logic [IW-1:0] idx);
        logic [IW-1:0] res;
        logic          found;
        int unsigned   cand;
        res   = idx;
        found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = d ? (32'(idx) + k) % N : (32'(idx) + N - k) % N;
            if (!found && m[cand]) begin
                res   = IW'(cand);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    assign nxt_idx = next_phase(mask_q, dir_q, idx_q);
    assign wrap    = (nxt_idx == first_phase(mask_q, dir_q));

    always_comb begin
        state_d     = state_q;
        out_d       = '0;
        idx_d       = idx_q;
        dwell_cnt_d = dwell_cnt_q;
        round_cnt_d = round_cnt_q;
        dwell_d     = dwell_q;
        rounds_d    = rounds_q;
        mask_d      = mask_q;
        dir_d       = dir_q;
        case (state_q)
            StIdle: begin
                if (start && !stop && (mask != '0)) begin
                    state_d     = StRun;
                    dwell_d     = dwell;
                    rounds_d    = rounds;
                    mask_d      = mask;
                    dir_d       = dir;
                    idx_d       = first_phase(mask, dir);
                    out_d       = onehot(idx_d);
                    dwell_cnt_d = '0;
                    round_cnt_d = '0;
                end
            end
            StRun: begin
                out_d = out_q;
                if (stop) begin
                    state_d = StIdle;
                    out_d   = '0;
                end else if (dwell_cnt_q == dwell_q) begin
                    dwell_cnt_d = '0;
                    // rounds=0 never terminates, so counter wrap-around is harmless
                    if (wrap && (rounds_q != '0) && (round_cnt_q + 1'b1 == rounds_q)) begin
                        state_d = StDone;
                        out_d   = '0;
                    end else begin
                        if (wrap) round_cnt_d = round_cnt_q + 1'b1;
                        idx_d = nxt_idx;
                        out_d = onehot(nxt_idx);
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_q       <= '0;
            idx_q       <= '0;
            dwell_cnt_q <= '0;
            round_cnt_q <= '0;
            dwell_q     <= '0;
            rounds_q    <= '0;
            mask_q      <= '0;
            dir_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            idx_q       <= idx_d;
            dwell_cnt_q <= dwell_cnt_d;
            round_cnt_q <= round_cnt_d;
            dwell_q     <= dwell_d;
            rounds_q    <= rounds_d;
            mask_q      <= mask_d;
            dir_q       <= dir_d;
        end
    end

    assign out  = out_q;
    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Bench for pulse_seq_ctrl: directed cases plus randomized runs checked against a
// phase-list model built from the enabled mask bits, dwell and round count.
module tb_pulse_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] dwell = '0;
    logic [7:0] rounds = '0;
    logic [3:0] mask = '0;
    logic       dir = 1'b0;
    logic [3:0] out;
    logic       busy;
    logic       done;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] exp_q[$];

    pulse_seq_ctrl #(.N(4), .DW(8), .RW(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .dwell  (dwell),
        .rounds (rounds),
        .mask   (mask),
        .dir    (dir),
        .out    (out),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected out per RUN cycle: enabled phases in order, each held dwell+1 cycles.
    task automatic build(input logic [3:0] m, input int dw, input int rn, input logic d);
        int ph[$];
        logic [3:0] one;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            int p;
            p = d ? i : 3 - i;
            if (m[p]) ph.push_back(p);
        end
        for (int r = 0; r < rn; r++)
            foreach (ph[j])
                for (int c = 0; c <= dw; c++) begin
                    one = 4'b0001;
                    exp_q.push_back(one << ph[j]);
                end
    endtask

    // stop_after=0: run to completion; otherwise assert stop after that many RUN cycles.
    task automatic run(input logic [3:0] m, input int dw, input int rn, input logic d,
                       input bit disturb, input int stop_after);
        int len;
        @(negedge clk);
        mask = m; dwell = 8'(dw); rounds = 8'(rn); dir = d; start = 1'b1; stop = 1'b0;
        @(negedge clk);
        start = 1'b0;
        build(m, dw, (stop_after != 0) ? stop_after + 1 : rn, d);
        len = (stop_after != 0) ? stop_after : exp_q.size();
        for (int i = 0; i < len; i++) begin
            check("run_out", 32'(out), 32'(exp_q[i]));
            check("run_busy", 32'(busy), 32'd1);
            check("run_done", 32'(done), 32'd0);
            if (disturb && i < len - 1) begin
                start = 1'($urandom); mask = 4'($urandom); dwell = 8'($urandom);
                rounds = 8'($urandom); dir = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            if (stop_after != 0 && i == len - 1) stop = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        check("end_out", 32'(out), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("end_done", 32'(done), (stop_after != 0) ? 32'd0 : 32'd1);
        stop = 1'b0;
        @(negedge clk);
        check("after_done", 32'(done), 32'd0);
        check("after_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #3;
        check("rst_out", 32'(out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(4'b1111, 0, 1, 1'b0, 1'b0, 0);
        run(4'b1010, 2, 2, 1'b0, 1'b0, 0);
        run(4'b1111, 0, 0, 1'b1, 1'b0, 10);

        // mask=0 start is ignored
        @(negedge clk);
        mask = 4'b0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mask0_busy", 32'(busy), 32'd0);
        check("mask0_out", 32'(out), 32'd0);
        check("mask0_done", 32'(done), 32'd0);
        // start with stop in the same cycle stays idle
        mask = 4'b1111; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("ststop_busy", 32'(busy), 32'd0);
        check("ststop_out", 32'(out), 32'd0);
        @(negedge clk);
        check("ststop_busy2", 32'(busy), 32'd0);

        // asynchronous reset mid-sequence
        mask = 4'b1111; dwell = 8'd0; rounds = 8'd1; dir = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pre_rst_out0", 32'(out), 32'h8);
        @(negedge clk);
        check("pre_rst_out1", 32'(out), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(out), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(4'b1111, 0, 1, 1'b0, 1'b0, 0);

        // config changes and start pulses during RUN have no effect
        run(4'b0100, 1, 3, 1'b0, 1'b1, 0);
        // continuous single phase beyond round-counter wrap-around
        run(4'b0010, 0, 0, 1'b1, 1'b0, 300);

        for (int t = 0; t < 20; t++)
            run(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(1, 3),
                1'($urandom), 1'b1, 0);
        run(4'($urandom_range(1, 15)), $urandom_range(0, 2), 0, 1'($urandom), 1'b1,
            $urandom_range(5, 40));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
